// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory responder.
// Block type, FSM states and block size.
package mips_mem_pkg;

    localparam int MEM_BLOCK_BYTES = 4;

    typedef logic [7:0] mem_block_t [0:MEM_BLOCK_BYTES-1];

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_DONE
    } mem_state_e;

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with block-wide ports.
// Synchronous 4-byte write, combinational 4-byte read.
module mem_byte_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-3:0] waddr_i,
    input  mem_block_t           wdata_i,
    input  logic [ADDR_BITS-3:0] raddr_i,
    output mem_block_t           rdata_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [7:0] mem_q [0:DEPTH-1];

    // Commit all bytes of the block on the aligned base.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < MEM_BLOCK_BYTES; i++) begin
                mem_q[{waddr_i, 2'(i)}] <= wdata_i[i];
            end
        end
    end

    // Gather the block; byte 0 sits at the lowest address.
    always_comb begin
        for (int i = 0; i < MEM_BLOCK_BYTES; i++) begin
            rdata_o[i] = mem_q[{raddr_i, 2'(i)}];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Slow main-memory model behind the MEM-stage cache.
// Fixed-latency block read/write with served-block tracking.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] mem_addr,
    input  mem_block_t  mem_data_in,
    input  logic        mem_write_en,
    input  logic        halted,
    output mem_block_t  mem_data_out,
    output logic        mem_ready
);

    localparam int         BW       = ADDR_BITS - 2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam logic       DIRECT   = (LATENCY == 1);

    mem_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    mem_block_t      wdata_q, wdata_d;
    logic [BW-1:0]   srv_addr_q, srv_addr_d;
    logic            srv_vld_q, srv_vld_d;
    mem_block_t      dout_q, dout_d;

    logic [BW-1:0]   blk_in;
    logic            accept;
    logic            complete;
    logic [BW-1:0]   cur_addr;
    logic            cur_we;
    mem_block_t      cur_wdata;
    mem_block_t      rd_data;
    logic            mem_we;
    logic            unused_addr_bits;

    assign blk_in           = mem_addr[ADDR_BITS-1:2];
    assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

    assign accept = (state_q == MEM_IDLE) && !halted &&
                    (mem_write_en || !srv_vld_q ||
                     (blk_in != srv_addr_q));

    // Live inputs when completing straight out of IDLE, latched ones otherwise.
    always_comb begin
        if (state_q == MEM_IDLE) begin
            cur_addr  = blk_in;
            cur_we    = mem_write_en;
            cur_wdata = mem_data_in;
        end else begin
            cur_addr  = addr_q;
            cur_we    = we_q;
            cur_wdata = wdata_q;
        end
    end

    // Next-state, latency counter and completion side effects.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        srv_addr_d = srv_addr_q;
        srv_vld_d  = srv_vld_q;
        dout_d     = dout_q;
        complete   = 1'b0;

        unique case (state_q)
            MEM_IDLE: begin
                if (accept) begin
                    addr_d  = blk_in;
                    we_d    = mem_write_en;
                    wdata_d = mem_data_in;
                    cnt_d   = CNT_LOAD;
                    if (DIRECT) begin
                        state_d  = MEM_DONE;
                        complete = 1'b1;
                    end else begin
                        state_d = MEM_BUSY;
                    end
                end
            end
            MEM_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = MEM_DONE;
                    complete = 1'b1;
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase

        if (complete) begin
            srv_addr_d = cur_addr;
            srv_vld_d  = 1'b1;
            if (cur_we) begin
                dout_d = cur_wdata;
            end else begin
                dout_d = rd_data;
            end
        end
    end

    // A reset on the completion edge abandons the write.
    assign mem_we = complete && cur_we && !rst_b;

    mem_byte_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (cur_addr),
        .wdata_i (cur_wdata),
        .raddr_i (cur_addr),
        .rdata_o (rd_data)
    );

    // Control and output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= 4'd0;
            srv_vld_q  <= 1'b0;
            srv_addr_q <= '0;
            dout_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            srv_vld_q  <= srv_vld_d;
            srv_addr_q <= srv_addr_d;
            dout_q     <= dout_d;
        end
    end

    // Request latches; only meaningful while a transaction is in flight.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    assign mem_data_out = dout_q;
    assign mem_ready    = (state_q == MEM_DONE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Two instances: LATENCY=4 and LATENCY=1.
module tb_data_mem_responder;
    import mips_mem_pkg::*;

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    int unsigned cyc = 0;
    int          checks = 0;
    int          passes = 0;

    logic        rst0, we0, halt0, rdy0;
    logic [31:0] addr0;
    mem_block_t  din0, dout0;
    logic        rst1, we1, halt1, rdy1;
    logic [31:0] addr1;
    mem_block_t  din1, dout1;

    exp_t q0[$];
    exp_t q1[$];

    data_mem_responder #(.ADDR_BITS(16), .LATENCY(4)) u0 (
        .clk          (clk),
        .rst_b        (rst0),
        .mem_addr     (addr0),
        .mem_data_in  (din0),
        .mem_write_en (we0),
        .halted       (halt0),
        .mem_data_out (dout0),
        .mem_ready    (rdy0)
    );

    data_mem_responder #(.ADDR_BITS(16), .LATENCY(1)) u1 (
        .clk          (clk),
        .rst_b        (rst1),
        .mem_addr     (addr1),
        .mem_data_in  (din1),
        .mem_write_en (we1),
        .halted       (halt1),
        .mem_data_out (dout1),
        .mem_ready    (rdy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pk(input mem_block_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic mem_block_t unpk(input logic [31:0] w);
        mem_block_t b;
        for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s got=%h want=%h", nm, got, want);
    endtask

    task automatic judge(input int k, input logic rdy,
                         input logic [31:0] d);
        exp_t e;
        bit   have;
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (k == 0) ? q0[0] : q1[0];
        if (rdy) begin
            checks++;
            if (!have) begin
                $display("FAIL u%0d spurious ready cyc=%0d data=%h want=no-ready",
                         k, cyc, d);
            end else begin
                if (k == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                if (e.cyc == cyc && e.data === d) passes++;
                else $display("FAIL u%0d ready got cyc=%0d data=%h want cyc=%0d data=%h",
                              k, cyc, d, e.cyc, e.data);
            end
        end else if (have && e.cyc < cyc) begin
            checks++;
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            $display("FAIL u%0d missed ready got=none want cyc=%0d data=%h",
                     k, e.cyc, e.data);
        end
    endtask

    // Monitor: every mem_ready must match the head of its queue.
    always @(negedge clk) begin
        judge(0, rdy0, pk(dout0));
        judge(1, rdy1, pk(dout1));
    end

    // Issue one request now (caller is at a negedge with the DUT idle).
    task automatic req(input int k, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [31:0] xd);
        exp_t        e;
        int unsigned l;
        l      = (k == 0) ? 4 : 1;
        e.cyc  = cyc + l;
        e.data = xd;
        if (k == 0) begin
            addr0 = a; we0 = w; din0 = unpk(wd); q0.push_back(e);
        end else begin
            addr1 = a; we1 = w; din1 = unpk(wd); q1.push_back(e);
        end
        @(negedge clk);
        if (k == 0) we0 = 1'b0;
        else        we1 = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst0 = 1'b1; we0 = 1'b0; halt0 = 1'b1; addr0 = '0;
        din0 = unpk(32'h0);
        rst1 = 1'b1; we1 = 1'b0; halt1 = 1'b1; addr1 = '0;
        din1 = unpk(32'h0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, rdy0}, 32'd0);
        chk("reset_dout", pk(dout0), 32'h0);
        chk("reset_ready_l1", {31'd0, rdy1}, 32'd0);

        // Test 1: write block 0x4.
        halt0 = 1'b0;
        req(0, 32'h4, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);

        // Test 2: reset keeps storage; read 0x4 then hold the address.
        halt0 = 1'b1; rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("rst2_dout", pk(dout0), 32'h0);
        halt0 = 1'b0;
        req(0, 32'h4, 1'b0, 32'h0, 32'hDEADBEEF);
        repeat (10) @(negedge clk);

        // Seed blocks for later reads.
        req(0, 32'h8, 1'b1, 32'h01020304, 32'h01020304);
        req(0, 32'hC, 1'b1, 32'hA0B1C2D3, 32'hA0B1C2D3);
        req(0, 32'h10, 1'b1, 32'h5AA53CC3, 32'h5AA53CC3);
        req(0, 32'hC, 1'b0, 32'h0, 32'hA0B1C2D3);

        // Test 3: address change mid-transaction.
        addr0 = 32'h8; we0 = 1'b0;
        e.cyc = cyc + 4; e.data = 32'h01020304; q0.push_back(e);
        e.cyc = cyc + 9; e.data = 32'hA0B1C2D3; q0.push_back(e);
        repeat (2) @(negedge clk);
        addr0 = 32'hC;
        repeat (8) @(negedge clk);

        // Test 5: halted blocks accept; halt during BUSY does not abort.
        halt0 = 1'b1; addr0 = 32'h10;
        repeat (20) @(negedge clk);
        halt0 = 1'b0;
        e.cyc = cyc + 4; e.data = 32'h5AA53CC3; q0.push_back(e);
        repeat (2) @(negedge clk);
        halt0 = 1'b1;
        repeat (3) @(negedge clk);

        // Test 4: reset mid-write abandons it.
        halt0 = 1'b0; addr0 = 32'h4; we0 = 1'b1;
        din0 = unpk(32'h11223344);
        @(negedge clk);
        we0 = 1'b0;
        @(negedge clk);
        rst0 = 1'b1; halt0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("rst4_ready", {31'd0, rdy0}, 32'd0);
        chk("rst4_dout", pk(dout0), 32'h0);
        repeat (4) @(negedge clk);
        halt0 = 1'b0;
        req(0, 32'h4, 1'b0, 32'h0, 32'hDEADBEEF);
        halt0 = 1'b1;

        // Test 6: LATENCY=1 with address wrap.
        halt1 = 1'b0;
        req(1, 32'h0001_0000, 1'b1, 32'hCAFEBABE, 32'hCAFEBABE);
        req(1, 32'h0000_0004, 1'b1, 32'h0F1E2D3C, 32'h0F1E2D3C);
        req(1, 32'h0000_0000, 1'b0, 32'h0, 32'hCAFEBABE);
        req(1, 32'h0001_0004, 1'b0, 32'h0, 32'h0F1E2D3C);
        repeat (4) @(negedge clk);
        chk("l1_hold_dout", pk(dout1), 32'h0F1E2D3C);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
